// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands and control, detects
// load-use hazards, applies forwarding selects and counts stall cycles.
module id_ex_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_op1_addr,
  input  logic [REG_AW-1:0] id_op2_addr,
  input  logic [DATA_W-1:0] id_op1_data,
  input  logic [DATA_W-1:0] id_op2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_use_imm,
  input  logic [3:0]        id_alu_op,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              branch_flush,
  input  logic [1:0]        forward_a,
  input  logic [1:0]        forward_b,
  input  logic [DATA_W-1:0] ex_mem_result,
  input  logic [DATA_W-1:0] mem_wb_result,
  output logic              stall,
  output logic              ex_valid,
  output logic [REG_AW-1:0] ex_op1_addr,
  output logic [REG_AW-1:0] ex_op2_addr,
  output logic [3:0]        ex_alu_op,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic [DATA_W-1:0] ex_alu_a,
  output logic [DATA_W-1:0] ex_alu_b,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [CNT_W-1:0]  stall_count
);

  logic              valid_r;
  logic [REG_AW-1:0] op1_addr_r;
  logic [REG_AW-1:0] op2_addr_r;
  logic [DATA_W-1:0] op1_data_r;
  logic [DATA_W-1:0] op2_data_r;
  logic [DATA_W-1:0] imm_r;
  logic              use_imm_r;
  logic [3:0]        alu_op_r;
  logic              reg_write_r;
  logic              mem_read_r;
  logic              mem_write_r;
  logic [CNT_W-1:0]  stall_count_r;

  logic              haz_s;
  logic              stall_s;
  logic [DATA_W-1:0] fwd_a_s;
  logic [DATA_W-1:0] fwd_b_s;

  // Load-use hazard detection and forwarding muxes; outputs held at zero in reset.
  always_comb begin
    haz_s   = 1'b0;
    stall_s = 1'b0;
    fwd_a_s = {DATA_W{1'b0}};
    fwd_b_s = {DATA_W{1'b0}};
    if (valid_r && mem_read_r && id_valid && (op1_addr_r != {REG_AW{1'b0}}) &&
        ((op1_addr_r == id_op1_addr) || (op1_addr_r == id_op2_addr))) begin
      haz_s = 1'b1;
    end else begin
      haz_s = 1'b0;
    end
    stall_s = rst_n & haz_s & ~branch_flush;
    case (forward_a)
      2'b10:   fwd_a_s = ex_mem_result;
      2'b01:   fwd_a_s = mem_wb_result;
      default: fwd_a_s = op1_data_r;
    endcase
    case (forward_b)
      2'b10:   fwd_b_s = ex_mem_result;
      2'b01:   fwd_b_s = mem_wb_result;
      default: fwd_b_s = op2_data_r;
    endcase
    if (!rst_n) begin
      fwd_a_s = {DATA_W{1'b0}};
      fwd_b_s = {DATA_W{1'b0}};
    end else begin
      fwd_a_s = fwd_a_s;
      fwd_b_s = fwd_b_s;
    end
  end

  // Pipeline register: reset, then flush/stall bubble, then normal capture.
  always_ff @(posedge clk) begin
    if (!rst_n || branch_flush || stall_s) begin
      valid_r     <= 1'b0;
      op1_addr_r  <= {REG_AW{1'b0}};
      op2_addr_r  <= {REG_AW{1'b0}};
      op1_data_r  <= {DATA_W{1'b0}};
      op2_data_r  <= {DATA_W{1'b0}};
      imm_r       <= {DATA_W{1'b0}};
      use_imm_r   <= 1'b0;
      alu_op_r    <= 4'h0;
      reg_write_r <= 1'b0;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
    end else begin
      valid_r     <= id_valid;
      op1_addr_r  <= id_op1_addr;
      op2_addr_r  <= id_op2_addr;
      op1_data_r  <= id_op1_data;
      op2_data_r  <= id_op2_data;
      imm_r       <= id_imm;
      use_imm_r   <= id_use_imm;
      alu_op_r    <= id_alu_op;
      reg_write_r <= id_valid & id_reg_write;
      mem_read_r  <= id_valid & id_mem_read;
      mem_write_r <= id_valid & id_mem_write;
    end
  end

  // Saturating stall-cycle counter, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_count_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_count_r != {CNT_W{1'b1}})) begin
      stall_count_r <= stall_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_count_r <= stall_count_r;
    end
  end

  assign stall         = stall_s;
  assign ex_valid      = valid_r;
  assign ex_op1_addr   = op1_addr_r;
  assign ex_op2_addr   = op2_addr_r;
  assign ex_alu_op     = alu_op_r;
  assign ex_reg_write  = reg_write_r & valid_r;
  assign ex_mem_read   = mem_read_r & valid_r;
  assign ex_mem_write  = mem_write_r & valid_r;
  assign ex_alu_a      = fwd_a_s;
  assign ex_alu_b      = use_imm_r ? imm_r : fwd_b_s;
  assign ex_store_data = fwd_b_s;
  assign stall_count   = stall_count_r;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; a second instance with a
// 4-bit counter exercises counter saturation within a short run.
module tb_id_ex_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_use_imm, id_reg_write, id_mem_read, id_mem_write;
  logic [3:0]  id_op1_addr, id_op2_addr, id_alu_op;
  logic [15:0] id_op1_data, id_op2_data, id_imm;
  logic        branch_flush;
  logic [1:0]  forward_a, forward_b;
  logic [15:0] ex_mem_result, mem_wb_result;
  logic        stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [3:0]  ex_op1_addr, ex_op2_addr, ex_alu_op;
  logic [15:0] ex_alu_a, ex_alu_b, ex_store_data, stall_count;
  logic        s_stall, s_valid, s_rw, s_mr, s_mw;
  logic [3:0]  s_a1, s_a2, s_op, s_count;
  logic [15:0] s_alu_a, s_alu_b, s_store;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op1_addr(id_op1_addr),
    .id_op2_addr(id_op2_addr), .id_op1_data(id_op1_data), .id_op2_data(id_op2_data),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_op(id_alu_op),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .branch_flush(branch_flush), .forward_a(forward_a), .forward_b(forward_b),
    .ex_mem_result(ex_mem_result), .mem_wb_result(mem_wb_result), .stall(stall),
    .ex_valid(ex_valid), .ex_op1_addr(ex_op1_addr), .ex_op2_addr(ex_op2_addr),
    .ex_alu_op(ex_alu_op), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b),
    .ex_store_data(ex_store_data), .stall_count(stall_count)
  );

  id_ex_stage #(.DATA_W(16), .REG_AW(4), .CNT_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_op1_addr(id_op1_addr),
    .id_op2_addr(id_op2_addr), .id_op1_data(id_op1_data), .id_op2_data(id_op2_data),
    .id_imm(id_imm), .id_use_imm(id_use_imm), .id_alu_op(id_alu_op),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .branch_flush(branch_flush), .forward_a(forward_a), .forward_b(forward_b),
    .ex_mem_result(ex_mem_result), .mem_wb_result(mem_wb_result), .stall(s_stall),
    .ex_valid(s_valid), .ex_op1_addr(s_a1), .ex_op2_addr(s_a2),
    .ex_alu_op(s_op), .ex_reg_write(s_rw), .ex_mem_read(s_mr),
    .ex_mem_write(s_mw), .ex_alu_a(s_alu_a), .ex_alu_b(s_alu_b),
    .ex_store_data(s_store), .stall_count(s_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [3:0] a1, input logic [3:0] a2,
                        input logic [15:0] d1, input logic [15:0] d2,
                        input logic rw, input logic mr);
    id_valid = v; id_op1_addr = a1; id_op2_addr = a2;
    id_op1_data = d1; id_op2_data = d2; id_reg_write = rw; id_mem_read = mr;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_id(1'b1, 4'd1, 4'd0, 16'h1234, 16'h0000, 1'b1, 1'b0);
    step(); step();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %h exp 0", ex_valid); end
    checks++; if (ex_alu_a !== 16'h0000) begin errors++; $display("FAIL reset_alu_a got %h exp 0000", ex_alu_a); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %h exp 0", stall); end
    checks++; if (stall_count !== 16'h0000) begin errors++; $display("FAIL reset_count got %h exp 0000", stall_count); end
    rst_n = 1'b1;
    step();
    checks++; if (ex_alu_a !== 16'h1234) begin errors++; $display("FAIL reset_release got %h exp 1234", ex_alu_a); end
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL reset_release_valid got %h exp 1", ex_valid); end
  endtask

  task automatic test_pass_through();
    id_alu_op = 4'h2;
    set_id(1'b1, 4'd3, 4'd4, 16'h0005, 16'h0007, 1'b1, 1'b0);
    step();
    checks++; if (ex_op1_addr !== 4'd3) begin errors++; $display("FAIL pt_op1_addr got %h exp 3", ex_op1_addr); end
    checks++; if (ex_op2_addr !== 4'd4) begin errors++; $display("FAIL pt_op2_addr got %h exp 4", ex_op2_addr); end
    checks++; if (ex_alu_a !== 16'h0005) begin errors++; $display("FAIL pt_alu_a got %h exp 0005", ex_alu_a); end
    checks++; if (ex_alu_b !== 16'h0007) begin errors++; $display("FAIL pt_alu_b got %h exp 0007", ex_alu_b); end
    checks++; if (ex_reg_write !== 1'b1) begin errors++; $display("FAIL pt_reg_write got %h exp 1", ex_reg_write); end
    checks++; if (ex_alu_op !== 4'h2) begin errors++; $display("FAIL pt_alu_op got %h exp 2", ex_alu_op); end
    checks++; if (ex_mem_read !== 1'b0) begin errors++; $display("FAIL pt_mem_read got %h exp 0", ex_mem_read); end
  endtask

  task automatic test_forwarding();
    set_id(1'b1, 4'd5, 4'd6, 16'h0001, 16'h0002, 1'b1, 1'b0);
    step();
    ex_mem_result = 16'hAAAA; mem_wb_result = 16'h5555;
    forward_a = 2'b10; forward_b = 2'b01; #1;
    checks++; if (ex_alu_a !== 16'hAAAA) begin errors++; $display("FAIL fwd_a_exmem got %h exp AAAA", ex_alu_a); end
    checks++; if (ex_alu_b !== 16'h5555) begin errors++; $display("FAIL fwd_b_memwb got %h exp 5555", ex_alu_b); end
    forward_a = 2'b01; forward_b = 2'b10; #1;
    checks++; if (ex_alu_a !== 16'h5555) begin errors++; $display("FAIL fwd_a_memwb got %h exp 5555", ex_alu_a); end
    checks++; if (ex_store_data !== 16'hAAAA) begin errors++; $display("FAIL fwd_store_exmem got %h exp AAAA", ex_store_data); end
    forward_a = 2'b11; forward_b = 2'b00; #1;
    checks++; if (ex_alu_a !== 16'h0001) begin errors++; $display("FAIL fwd_a_11 got %h exp 0001", ex_alu_a); end
    checks++; if (ex_alu_b !== 16'h0002) begin errors++; $display("FAIL fwd_b_00 got %h exp 0002", ex_alu_b); end
    id_use_imm = 1'b1; id_imm = 16'h0010;
    step();
    forward_b = 2'b01; #1;
    checks++; if (ex_alu_b !== 16'h0010) begin errors++; $display("FAIL imm_alu_b got %h exp 0010", ex_alu_b); end
    checks++; if (ex_store_data !== 16'h5555) begin errors++; $display("FAIL imm_store got %h exp 5555", ex_store_data); end
    id_use_imm = 1'b0; id_imm = 16'h0000; forward_a = 2'b00; forward_b = 2'b00;
  endtask

  task automatic test_load_use();
    set_id(1'b1, 4'd2, 4'd0, 16'h0000, 16'h0000, 1'b1, 1'b1);
    step();
    set_id(1'b1, 4'd5, 4'd2, 16'h0050, 16'h0020, 1'b1, 1'b0);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %h exp 1", stall); end
    step();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got %h exp 0", ex_valid); end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL lu_count got %h exp 0001", stall_count); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_drop got %h exp 0", stall); end
    step();
    checks++; if (ex_valid !== 1'b1 || ex_op1_addr !== 4'd5 || ex_alu_a !== 16'h0050) begin
      errors++; $display("FAIL lu_enter got v=%h a=%h d=%h exp v=1 a=5 d=0050", ex_valid, ex_op1_addr, ex_alu_a);
    end
    checks++; if (stall_count !== 16'd1) begin errors++; $display("FAIL lu_count_hold got %h exp 0001", stall_count); end
  endtask

  task automatic test_back_to_back();
    set_id(1'b1, 4'd2, 4'd0, 16'h0000, 16'h0000, 1'b1, 1'b1);
    step();
    set_id(1'b1, 4'd3, 4'd2, 16'h0000, 16'h0000, 1'b1, 1'b1);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_stall1 got %h exp 1", stall); end
    step(); step();
    checks++; if (ex_mem_read !== 1'b1 || ex_op1_addr !== 4'd3) begin
      errors++; $display("FAIL b2b_load2 got mr=%h a=%h exp mr=1 a=3", ex_mem_read, ex_op1_addr);
    end
    set_id(1'b1, 4'd4, 4'd3, 16'h0000, 16'h0000, 1'b1, 1'b0);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_stall2 got %h exp 1", stall); end
    step();
    checks++; if (stall_count !== 16'd3) begin errors++; $display("FAIL b2b_count got %h exp 0003", stall_count); end
    step();
    checks++; if (ex_valid !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL b2b_enter got v=%h s=%h exp v=1 s=0", ex_valid, stall);
    end
  endtask

  task automatic test_no_stall();
    set_id(1'b1, 4'd0, 4'd0, 16'h0000, 16'h0000, 1'b1, 1'b1);
    step();
    set_id(1'b1, 4'd0, 4'd1, 16'h0000, 16'h0000, 1'b1, 1'b0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL r0_stall got %h exp 0", stall); end
    step();
    set_id(1'b1, 4'd2, 4'd0, 16'h0000, 16'h0000, 1'b1, 1'b1);
    step();
    set_id(1'b1, 4'd6, 4'd7, 16'h0000, 16'h0000, 1'b1, 1'b0);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL indep_stall got %h exp 0", stall); end
    step();
    checks++; if (ex_valid !== 1'b1 || ex_op1_addr !== 4'd6) begin
      errors++; $display("FAIL indep_enter got v=%h a=%h exp v=1 a=6", ex_valid, ex_op1_addr);
    end
  endtask

  task automatic test_flush();
    set_id(1'b1, 4'd2, 4'd0, 16'h0000, 16'h0000, 1'b1, 1'b1);
    step();
    set_id(1'b1, 4'd5, 4'd2, 16'h0000, 16'h0000, 1'b1, 1'b0);
    branch_flush = 1'b1; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %h exp 0", stall); end
    step();
    branch_flush = 1'b0; #1;
    checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin
      errors++; $display("FAIL flush_bubble got v=%h rw=%h exp v=0 rw=0", ex_valid, ex_reg_write);
    end
    checks++; if (stall_count !== 16'd3) begin errors++; $display("FAIL flush_count got %h exp 0003", stall_count); end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 16; i++) begin
      set_id(1'b1, 4'd2, 4'd0, 16'h0000, 16'h0000, 1'b1, 1'b1);
      step();
      set_id(1'b1, 4'd5, 4'd2, 16'h0000, 16'h0000, 1'b1, 1'b0);
      step(); step();
    end
    checks++; if (s_count !== 4'hF) begin errors++; $display("FAIL sat_small got %h exp F", s_count); end
    checks++; if (stall_count !== 16'd19) begin errors++; $display("FAIL sat_main got %h exp 0013", stall_count); end
  endtask

  initial begin
    rst_n = 1'b0; id_use_imm = 1'b0; id_imm = 16'h0000; id_alu_op = 4'h0;
    id_mem_write = 1'b0; branch_flush = 1'b0; forward_a = 2'b00; forward_b = 2'b00;
    ex_mem_result = 16'h0000; mem_wb_result = 16'h0000;
    test_reset();
    test_pass_through();
    test_forwarding();
    test_load_use();
    test_back_to_back();
    test_no_stall();
    test_flush();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the 16-register pipelined CPU, directly upstream of the forwarding unit.
- Captures decoded operands and control from ID and presents the EX register numbers to the forwarding unit.
- Consumes the forwarding unit's Forward_A/Forward_B selects to build the ALU operands.
- Detects load-use hazards, stalls IF/ID for one cycle, accepts branch flushes, and counts stall cycles.

Parameters:
DATA_W, 16, operand/result width
REG_AW, 4, register address width (register 0 never forwarded/hazarded)
CNT_W, 16, stall counter width

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  synchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_op1_addr  in  REG_AW  op1 register (also destination)
id_op2_addr  in  REG_AW  op2 register
id_op1_data  in  DATA_W  register-file read of op1
id_op2_data  in  DATA_W  register-file read of op2
id_imm  in  DATA_W  sign-extended immediate
id_use_imm  in  1  ALU B takes immediate
id_alu_op  in  4  ALU function
id_reg_write  in  1  writes op1 register
id_mem_read  in  1  load
id_mem_write  in  1  store
branch_flush  in  1  squash instruction entering EX
forward_a  in  2  from forwarding unit: 00 regfile, 10 EX/MEM, 01 MEM/WB
forward_b  in  2  same encoding for op2
ex_mem_result  in  DATA_W  EX/MEM ALU result
mem_wb_result  in  DATA_W  MEM/WB writeback data
stall  out  1  hold PC and IF/ID this cycle
ex_valid  out  1  EX holds a real instruction
ex_op1_addr  out  REG_AW  to forwarding unit (ID_EX_RegisterOp1)
ex_op2_addr  out  REG_AW  to forwarding unit (ID_EX_RegisterOp2)
ex_alu_op  out  4  registered ALU function
ex_reg_write  out  1  registered, gated by ex_valid
ex_mem_read  out  1  registered, gated by ex_valid
ex_mem_write  out  1  registered, gated by ex_valid
ex_alu_a  out  DATA_W  forwarded op1
ex_alu_b  out  DATA_W  immediate or forwarded op2
ex_store_data  out  DATA_W  forwarded op2 (never immediate)
stall_count  out  CNT_W  saturating count of stall cycles

Behaviour:
- Reset: on a clk edge with rst_n=0, every register clears. While reset holds, all outputs are 0, including stall and stall_count. Reset overrides flush and stall.
- Hazard (combinational from registered state and ID inputs):
  - haz = ex_valid & ex_mem_read & id_valid & (ex_op1_addr != 0) & (ex_op1_addr == id_op1_addr | ex_op1_addr == id_op2_addr).
  - stall = haz & ~branch_flush.
- Register update each edge (rst_n=1), in priority order:
  1. branch_flush=1: load a bubble. All fields clear and ex_valid=0.
  2. stall=1: load a bubble. The ID instruction is not captured; upstream re-presents it next cycle.
  3. otherwise: capture all id_* fields. ex_valid<=id_valid. When id_valid=0, control bits clear.
- Stall duration: exactly 1 cycle per load-use pair. After the bubble, ex_mem_read=0, so stall drops and the held instruction enters EX. The forwarding unit then selects MEM/WB (01).
- Back-to-back loads each produce an independent one-cycle stall if dependent.
- Operand mux (combinational, zero latency from forward_* and the registered data):
  - sel 00 or 11: registered regfile data.
  - sel 10: ex_mem_result.
  - sel 01: mem_wb_result.
  - ex_alu_b = ex_use_imm ? ex_imm : forwarded op2.
  - ex_store_data is always forwarded op2.
- Counter: stall_count increments by 1 on every edge where stall=1, saturates at all-ones, and clears only on reset.
- Register 0: a load to r0 never causes a stall.

Test Plan:
1. Reset: hold rst_n=0 for 2 edges with id_valid=1 and id_op1_data=0x1234 -> ex_valid=0, ex_alu_a=0, stall=0, stall_count=0. First edge after release captures 0x1234.
2. Pass-through: ADD r3,r4 with op1=0x0005, op2=0x0007, forward=00/00 -> next cycle ex_op1_addr=3, ex_op2_addr=4, ex_alu_a=0x0005, ex_alu_b=0x0007, ex_reg_write=1.
3. Forwarding mux: EX holds op1=0x0001, op2=0x0002, ex_mem_result=0xAAAA, mem_wb_result=0x5555. forward_a=10, forward_b=01 -> alu_a=0xAAAA, alu_b=0x5555. With use_imm=1 and imm=0x0010 -> alu_b=0x0010, store_data=0x5555.
4. Load-use: LOAD r2 in EX, ID presents ADD r5,r2 -> stall=1 for exactly one cycle, bubble enters EX (ex_valid=0), stall_count=1. The ADD enters EX on the following edge.
5. Load to r0 and independent load: LOAD r0 then ADD r0,r1 -> no stall. LOAD r2 then ADD r6,r7 -> no stall.
6. Flush vs stall: load-use condition with branch_flush=1 -> stall=0, EX gets a bubble, stall_count unchanged. Force 0xFFFF+2 stall cycles -> stall_count stays 0xFFFF.
